// File: rtl/lc4_divider_iter.sv
// Iterative unsigned 16-bit divider for the LC4 DIV/MOD instructions.
// Restoring algorithm, one quotient bit per cycle behind a start/busy/valid handshake.
module lc4_divider_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic        i_start,
  input  logic [15:0] i_dividend,
  input  logic [15:0] i_divisor,
  output logic        o_busy,
  output logic        o_valid,
  output logic [15:0] o_quotient,
  output logic [15:0] o_remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  count;
  logic [15:0] dvd;
  logic [15:0] dvs;
  logic [15:0] quo;
  logic [16:0] rem;

  logic [16:0] rem_shift;
  logic [16:0] rem_step;
  logic        q_bit;
  logic        accept;
  logic        last_step;

  // One restoring step. The 17th bit keeps the compare exact when the divisor is >= 0x8000.
  always_comb begin
    rem_shift = {rem[15:0], dvd[15]};
    q_bit     = (rem_shift >= {1'b0, dvs});
    rem_step  = q_bit ? (rem_shift - {1'b0, dvs}) : rem_shift;
    accept    = i_start && ((state == IDLE) || (state == DONE));
    last_step = (state == RUN) && (count == 5'd15);
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = (i_divisor == 16'd0) ? DONE : RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (accept) state_next = (i_divisor == 16'd0) ? DONE : RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (gwe) begin
      state <= state_next;
    end
  end

  // gwe=0 freezes the whole datapath, including the result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= 5'd0;
      dvd         <= 16'd0;
      dvs         <= 16'd0;
      quo         <= 16'd0;
      rem         <= 17'd0;
      o_quotient  <= 16'd0;
      o_remainder <= 16'd0;
    end else if (gwe) begin
      if (accept) begin
        dvd   <= i_dividend;
        dvs   <= i_divisor;
        quo   <= 16'd0;
        rem   <= 17'd0;
        count <= 5'd0;
        // Divide-by-zero completes immediately with both results zero.
        if (i_divisor == 16'd0) begin
          o_quotient  <= 16'd0;
          o_remainder <= 16'd0;
        end
      end else if (state == RUN) begin
        rem   <= rem_step;
        dvd   <= {dvd[14:0], 1'b0};
        quo   <= {quo[14:0], q_bit};
        count <= count + 5'd1;
        if (last_step) begin
          o_quotient  <= {quo[14:0], q_bit};
          o_remainder <= rem_step[15:0];
        end
      end
    end
  end

endmodule
